// File: rtl/idu_pkg.sv
// Shared decode-stage definitions: opcodes, type indices, decoded-entry record
// and skid-buffer state encoding.
package idu_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_OP_32  = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam int R_TYPE = 0;
   localparam int I_TYPE = 1;
   localparam int S_TYPE = 2;
   localparam int B_TYPE = 3;
   localparam int U_TYPE = 4;
   localparam int J_TYPE = 5;

   // The immediate is held at the widest XLEN; users keep the low XLEN bits.
   localparam int IMM_W = 64;

   typedef struct packed {
      logic             illegal;
      logic [5:0]       itype;
      logic             use_alu;
      logic             d0en;
      logic             s1en;
      logic             s2en;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [9:0]       fun;
      logic [6:0]       opcode;
      logic [IMM_W-1:0] imm;
   } idu_dec_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV64I instruction decoder producing one idu_dec_t record.
module idu_decode
   import idu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] inst,
   output idu_dec_t    dec
);

   localparam logic IS64 = (XLEN == 64);

   logic [6:0]  op;
   logic [6:0]  f7;
   logic [5:0]  itype;
   logic [31:0] imm32;
   logic        env;

   assign op  = inst[6:0];
   assign f7  = inst[31:25];
   assign env = (op == OP_SYSTEM);

   always_comb begin
      itype = '0;
      case (op)
         OP_OP:                               itype[R_TYPE] = 1'b1;
         OP_OP_32:                            itype[R_TYPE] = IS64;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: itype[I_TYPE] = 1'b1;
         OP_IMM_32:                           itype[I_TYPE] = IS64;
         OP_STORE:                            itype[S_TYPE] = 1'b1;
         OP_BRANCH:                           itype[B_TYPE] = 1'b1;
         OP_LUI, OP_AUIPC:                    itype[U_TYPE] = 1'b1;
         OP_JAL:                              itype[J_TYPE] = 1'b1;
         default:                             itype = '0;
      endcase
      // Only the base and alternate funct7 encodings exist for register ops.
      if (itype[R_TYPE] && (f7 != F7_BASE) && (f7 != F7_ALT)) itype = '0;
      if (inst[1:0] != 2'b11) itype = '0;
   end

   always_comb begin
      imm32 = '0;
      if (itype[I_TYPE])      imm32 = {{20{inst[31]}}, inst[31:20]};
      else if (itype[S_TYPE]) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      else if (itype[B_TYPE]) imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      else if (itype[U_TYPE]) imm32 = {inst[31:12], 12'b0};
      else if (itype[J_TYPE]) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   end

   always_comb begin
      dec         = '0;
      dec.illegal = ~|itype;
      dec.itype   = itype;
      dec.fun     = {inst[14:12], f7};
      dec.opcode  = op;
      dec.use_alu = itype[R_TYPE] | (itype[I_TYPE] & ((op == OP_IMM) | (op == OP_IMM_32)));
      dec.d0en    = (itype[R_TYPE] | itype[I_TYPE] | itype[U_TYPE] | itype[J_TYPE]) & ~env;
      dec.s1en    = (itype[R_TYPE] | itype[I_TYPE] | itype[S_TYPE] | itype[B_TYPE]) & ~env;
      dec.s2en    = itype[R_TYPE] | itype[S_TYPE] | itype[B_TYPE];
      dec.rd      = dec.d0en ? inst[11:7]  : 5'd0;
      dec.rs1     = dec.s1en ? inst[19:15] : 5'd0;
      dec.rs2     = dec.s2en ? inst[24:20] : 5'd0;
      dec.imm     = {{(IMM_W-32){imm32[31]}}, imm32};
   end

endmodule

// File: rtl/idu_stage.sv
// Instruction decode stage: decodes the fetched word, then holds results in a
// two-entry (main + skid) buffer so in_ready can come straight from a flop.
module idu_stage
   import idu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int INST_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [XLEN-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic              out_d0en,
   output logic              out_s1en,
   output logic              out_s2en,
   output logic [REG_AW-1:0] out_rd,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [XLEN-1:0]   out_imm,
   output logic [9:0]        out_fun,
   output logic [6:0]        out_opcode,
   output logic [5:0]        out_itype,
   output logic              out_use_alu,
   output logic              out_illegal
);

   buf_state_e      state_q, state_d;
   idu_dec_t        dec_in, main_q, skid_q;
   logic [XLEN-1:0] main_pc, skid_pc;
   logic            rdy_q;
   logic            accept, consume;
   logic            load_main, load_skid, shift_skid;
   logic            unused_imm_hi;

   idu_decode #(.XLEN(XLEN)) u_decode (
      .inst (in_inst),
      .dec  (dec_in)
   );

   // A transfer happens on a side exactly when valid && ready are both high at
   // the rising edge; valid never waits on ready. Flush cancels the in-side
   // transfer of its cycle, but an out-side transfer in that cycle still counts.
   assign out_valid = (state_q != BUF_EMPTY);
   assign in_ready  = rdy_q;
   assign accept    = in_valid && rdy_q && !flush;
   assign consume   = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
      case (state_q)
         BUF_EMPTY: if (accept) begin
            state_d   = BUF_ONE;
            load_main = 1'b1;
         end
         BUF_ONE: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = BUF_FULL;
               load_skid = 1'b1;
            end else if (consume) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: if (consume) begin
            state_d    = BUF_ONE;
            shift_skid = 1'b1;
         end
         default: state_d = BUF_EMPTY;
      endcase
      if (flush) state_d = BUF_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BUF_EMPTY;
         rdy_q   <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
         main_pc <= '0;
         skid_pc <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != BUF_FULL);
         if (load_main) begin
            main_q  <= dec_in;
            main_pc <= in_pc;
         end else if (shift_skid) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
         end
         if (load_skid) begin
            skid_q  <= dec_in;
            skid_pc <= in_pc;
         end
      end
   end

   assign out_pc      = main_pc;
   assign out_d0en    = main_q.d0en;
   assign out_s1en    = main_q.s1en;
   assign out_s2en    = main_q.s2en;
   assign out_rd      = REG_AW'(main_q.rd);
   assign out_rs1     = REG_AW'(main_q.rs1);
   assign out_rs2     = REG_AW'(main_q.rs2);
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fun     = main_q.fun;
   assign out_opcode  = main_q.opcode;
   assign out_itype   = main_q.itype;
   assign out_use_alu = main_q.use_alu;
   assign out_illegal = main_q.illegal;

   // Above XLEN the immediate bits are pure sign copies.
   assign unused_imm_hi = ^main_q.imm;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a queue-based reference of the decode stage.
module tb_idu_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [63:0] in_pc = '0;
   logic        out_ready = 1'b0;

   logic        r32_in_ready, r32_out_valid, r32_d0en, r32_s1en, r32_s2en, r32_use_alu, r32_illegal;
   logic [31:0] r32_pc, r32_imm;
   logic [4:0]  r32_rd, r32_rs1, r32_rs2;
   logic [9:0]  r32_fun;
   logic [6:0]  r32_opcode;
   logic [5:0]  r32_itype;

   logic        r64_in_ready, r64_out_valid, r64_d0en, r64_s1en, r64_s2en, r64_use_alu, r64_illegal;
   logic [63:0] r64_pc, r64_imm;
   logic [4:0]  r64_rd, r64_rs1, r64_rs2;
   logic [9:0]  r64_fun;
   logic [6:0]  r64_opcode;
   logic [5:0]  r64_itype;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int W = 96;  // {pc[63:0], inst[31:0]}
   logic [W-1:0] exp_q[$];
   logic         exp_in_ready = 1'b1;

   typedef struct packed {
      logic        ill;
      logic [5:0]  itype;
      logic        d0, s1, s2;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      logic        ua;
   } exp_t;

   idu_stage #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r32_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
      .out_valid(r32_out_valid), .out_ready(out_ready), .out_pc(r32_pc),
      .out_d0en(r32_d0en), .out_s1en(r32_s1en), .out_s2en(r32_s2en),
      .out_rd(r32_rd), .out_rs1(r32_rs1), .out_rs2(r32_rs2), .out_imm(r32_imm),
      .out_fun(r32_fun), .out_opcode(r32_opcode), .out_itype(r32_itype),
      .out_use_alu(r32_use_alu), .out_illegal(r32_illegal)
   );

   idu_stage #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r64_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(r64_out_valid), .out_ready(out_ready), .out_pc(r64_pc),
      .out_d0en(r64_d0en), .out_s1en(r64_s1en), .out_s2en(r64_s2en),
      .out_rd(r64_rd), .out_rs1(r64_rs1), .out_rs2(r64_rs2), .out_imm(r64_imm),
      .out_fun(r64_fun), .out_opcode(r64_opcode), .out_itype(r64_itype),
      .out_use_alu(r64_use_alu), .out_illegal(r64_illegal)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference decode written straight from the instruction-set tables.
   function automatic exp_t ref_dec(input logic [31:0] i, input bit is64);
      exp_t   r;
      int     kind;
      longint v;
      logic [6:0] op;
      logic       env;
      r  = '0;
      op = i[6:0];
      case (op)
         7'h33: kind = 0;
         7'h3b: kind = is64 ? 0 : -1;
         7'h13, 7'h03, 7'h67, 7'h73: kind = 1;
         7'h1b: kind = is64 ? 1 : -1;
         7'h23: kind = 2;
         7'h63: kind = 3;
         7'h37, 7'h17: kind = 4;
         7'h6f: kind = 5;
         default: kind = -1;
      endcase
      if (kind == 0 && !(i[31:25] == 7'h00 || i[31:25] == 7'h20)) kind = -1;
      if (kind < 0) begin
         r.ill = 1'b1;
         return r;
      end
      r.itype[kind] = 1'b1;
      env  = (op == 7'h73);
      r.d0 = (kind inside {0, 1, 4, 5}) && !env;
      r.s1 = (kind inside {0, 1, 2, 3}) && !env;
      r.s2 = kind inside {0, 2, 3};
      r.rd  = r.d0 ? i[11:7]  : 5'd0;
      r.rs1 = r.s1 ? i[19:15] : 5'd0;
      r.rs2 = r.s2 ? i[24:20] : 5'd0;
      case (kind)
         1: v = $signed(i[31:20]);
         2: v = $signed({i[31:25], i[11:7]});
         3: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
         4: v = $signed({i[31:12], 12'b0});
         5: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
         default: v = 0;
      endcase
      r.imm = is64 ? v : {32'b0, v[31:0]};
      r.ua  = (kind == 0) || (op == 7'h13) || (op == 7'h1b);
      return r;
   endfunction

   task automatic check_dut(input string n, input bit is64, input logic ov, input logic ir,
                            input logic [63:0] pc, input logic d0, input logic s1, input logic s2,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] imm, input logic [9:0] fun, input logic [6:0] opc,
                            input logic [5:0] it, input logic ua, input logic il);
      exp_t        e;
      logic [31:0] ei;
      logic [63:0] epc;
      check({n, ".in_ready"}, ir, exp_in_ready);
      check({n, ".out_valid"}, ov, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         ei  = exp_q[0][31:0];
         epc = is64 ? exp_q[0][95:32] : {32'b0, exp_q[0][63:32]};
         e   = ref_dec(ei, is64);
         check({n, ".pc"}, pc, epc);
         check({n, ".illegal"}, il, e.ill);
         check({n, ".itype"}, it, e.itype);
         check({n, ".d0en"}, d0, e.d0);
         check({n, ".s1en"}, s1, e.s1);
         check({n, ".s2en"}, s2, e.s2);
         check({n, ".rd"}, rd, e.rd);
         check({n, ".rs1"}, rs1, e.rs1);
         check({n, ".rs2"}, rs2, e.rs2);
         check({n, ".imm"}, imm, e.imm);
         check({n, ".use_alu"}, ua, e.ua);
         check({n, ".fun"}, fun, {ei[14:12], ei[31:25]});
         check({n, ".opcode"}, opc, ei[6:0]);
      end
   endtask

   task automatic check_all();
      check_dut("x32", 1'b0, r32_out_valid, r32_in_ready, {32'b0, r32_pc}, r32_d0en, r32_s1en,
                r32_s2en, r32_rd, r32_rs1, r32_rs2, {32'b0, r32_imm}, r32_fun, r32_opcode,
                r32_itype, r32_use_alu, r32_illegal);
      check_dut("x64", 1'b1, r64_out_valid, r64_in_ready, r64_pc, r64_d0en, r64_s1en,
                r64_s2en, r64_rd, r64_rs1, r64_rs2, r64_imm, r64_fun, r64_opcode,
                r64_itype, r64_use_alu, r64_illegal);
   endtask

   // driver: one clock cycle of stimulus, then update the reference and compare
   task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                       input logic ordy, input logic fl);
      bit acc, cons;
      @(negedge clk);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      acc  = v && exp_in_ready && !fl;
      cons = (exp_q.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (cons) void'(exp_q.pop_front());
         if (fl) exp_q.delete();
         else if (acc) exp_q.push_back({pc, inst});
      end
      exp_in_ready = (exp_q.size() < 2);
      check_all();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  ops[12];
      ops = '{7'h33, 7'h3b, 7'h13, 7'h03, 7'h67, 7'h73, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
         w[6:0] = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      end
      return w;
   endfunction

   function automatic logic [63:0] rand_pc();
      return {$urandom, $urandom};
   endfunction

   initial begin
      // reset
      rst = 1'b1;
      step(1'b1, 32'hFFF08293, 64'h40, 1'b1, 1'b0);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      check("rst.imm32", {32'b0, r32_imm}, 64'h0);
      check("rst.pc32", {32'b0, r32_pc}, 64'h0);
      check("rst.imm64", r64_imm, 64'h0);
      check("rst.rd", r32_rd, 0);
      check("rst.fun", r32_fun, 0);
      rst = 1'b0;

      // addi x5,x1,-1
      step(1'b1, 32'hFFF08293, 64'h100, 1'b1, 1'b0);
      check("addi.valid", r32_out_valid, 1);
      check("addi.itype", r32_itype, 6'b000010);
      check("addi.rd", r32_rd, 5);
      check("addi.rs1", r32_rs1, 1);
      check("addi.en", {r32_d0en, r32_s1en, r32_s2en}, 3'b110);
      check("addi.imm", {32'b0, r32_imm}, 64'hFFFFFFFF);
      check("addi.use_alu", r32_use_alu, 1);

      // back-to-back lui / sw / beq / jal
      step(1'b1, 32'h123450B7, 64'h104, 1'b1, 1'b0);
      check("lui.imm", {32'b0, r32_imm}, 64'h12345000);
      check("lui.rd", r32_rd, 1);
      step(1'b1, 32'h0021A423, 64'h108, 1'b1, 1'b0);
      check("sw.imm", {32'b0, r32_imm}, 64'h8);
      check("sw.d0en", r32_d0en, 0);
      check("sw.rs", {r32_rs1, r32_rs2}, {5'd3, 5'd2});
      step(1'b1, 32'hFE000EE3, 64'h10C, 1'b1, 1'b0);
      check("beq.imm", {32'b0, r32_imm}, 64'hFFFFFFFC);
      check("beq.imm64", r64_imm, 64'hFFFFFFFFFFFFFFFC);
      check("beq.d0en", r32_d0en, 0);
      step(1'b1, 32'h010000EF, 64'h110, 1'b1, 1'b0);
      check("jal.imm", {32'b0, r32_imm}, 64'h10);
      check("jal.s1en", r32_s1en, 0);
      check("jal.pc", {32'b0, r32_pc}, 64'h110);
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // stall: two accepted, third held off
      step(1'b1, 32'h00100093, 64'h200, 1'b0, 1'b0);
      step(1'b1, 32'h00200113, 64'h204, 1'b0, 1'b0);
      check("stall.in_ready", r32_in_ready, 0);
      step(1'b1, 32'h00300193, 64'h208, 1'b0, 1'b0);
      check("stall.head", {32'b0, r32_pc}, 64'h200);
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      check("drain.second", {32'b0, r32_pc}, 64'h204);
      check("drain.in_ready", r32_in_ready, 1);
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      check("drain.empty", r32_out_valid, 0);

      // flush while full
      step(1'b1, 32'h00400213, 64'h300, 1'b0, 1'b0);
      step(1'b1, 32'h00500293, 64'h304, 1'b0, 1'b0);
      step(1'b1, 32'h00600313, 64'h308, 1'b0, 1'b1);
      check("flush.valid", r32_out_valid, 0);
      check("flush.in_ready", r32_in_ready, 1);
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      check("flush.stays_empty", r32_out_valid, 0);

      // illegal words and the RV64-only addiw
      step(1'b1, 32'h00000000, 64'h400, 1'b1, 1'b0);
      check("zero.illegal", r32_illegal, 1);
      check("zero.itype", r32_itype, 0);
      step(1'b1, 32'hFFF0829B, 64'h404, 1'b1, 1'b0);
      check("addiw32.illegal", r32_illegal, 1);
      check("addiw32.en", {r32_d0en, r32_s1en, r32_s2en}, 3'b000);
      check("addiw64.itype", r64_itype, 6'b000010);
      check("addiw64.illegal", r64_illegal, 0);
      step(1'b1, 32'h00000073, 64'h408, 1'b1, 1'b0);
      check("ecall.itype", r32_itype, 6'b000010);
      check("ecall.en", {r32_d0en, r32_s1en, r32_illegal, r32_use_alu}, 4'b0000);

      // randomized traffic with occasional flush and reset
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 299) == 0);
         step($urandom_range(0, 3) != 0, rand_inst(), rand_pc(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
